// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//
// Pipeline register between the MEM and WB stages of an RV32I core. It picks
// the writeback value (ALU result, formatted load, or PC+4), registers it
// together with the destination index and write enable, and counts retired
// instructions.
//
// Ports
//   clk             rising-edge clock
//   reset           synchronous, active-high reset
//   mem_valid       MEM stage holds a valid instruction
//   mem_rd          destination register index
//   mem_reg_write   instruction writes rd
//   mem_wb_sel      writeback source: 00 ALU, 01 load, 10 PC+4, 11 reserved (0)
//   mem_alu_result  ALU result; byte address for loads
//   mem_pc_plus4    PC+4 of the instruction
//   mem_load_data   raw aligned word from data memory
//   mem_funct3      load size/sign code
//   stall           hold all WB registers and instret
//   flush           squash the instruction entering WB
//   wb_rd           register-file write index
//   wb_write_data   register-file write data
//   wb_wr_en        register-file write enable
//   wb_valid        WB holds a valid instruction
//   instret         retired-instruction counter
// -----------------------------------------------------------------------------

package mem_wb_pkg;
    parameter int XLEN           = 32;
    parameter int REG_ADDR_WIDTH = 5;
endpackage

module mem_wb_stage
    import mem_wb_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mem_valid,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
    input  logic                      mem_reg_write,
    input  logic [1:0]                mem_wb_sel,
    input  logic [XLEN-1:0]           mem_alu_result,
    input  logic [XLEN-1:0]           mem_pc_plus4,
    input  logic [XLEN-1:0]           mem_load_data,
    input  logic [2:0]                mem_funct3,
    input  logic                      stall,
    input  logic                      flush,
    output logic [REG_ADDR_WIDTH-1:0] wb_rd,
    output logic [XLEN-1:0]           wb_write_data,
    output logic                      wb_wr_en,
    output logic                      wb_valid,
    output logic [63:0]               instret
);

    // -------------------------------------------------------------------------
    // Load formatting
    // -------------------------------------------------------------------------
    logic [7:0]      lane_byte [4];
    logic [1:0]      load_offset;
    logic [7:0]      sel_byte;
    logic [15:0]     sel_half;
    logic [XLEN-1:0] load_formatted;

    assign load_offset = mem_alu_result[1:0];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_byte[gi] = mem_load_data[8*gi +: 8];
        end
    endgenerate

    // Halfword select uses only offset[1]; an odd halfword address is
    // silently rounded down rather than trapping.
    assign sel_byte = lane_byte[load_offset];
    assign sel_half = load_offset[1] ? mem_load_data[31:16] : mem_load_data[15:0];

    always_comb begin
        load_formatted = mem_load_data;
        case (mem_funct3)
            3'b000:  load_formatted = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  load_formatted = {24'h0, sel_byte};
            3'b001:  load_formatted = {{16{sel_half[15]}}, sel_half};
            3'b101:  load_formatted = {16'h0, sel_half};
            default: load_formatted = mem_load_data;
        endcase
    end

    // -------------------------------------------------------------------------
    // Writeback value select
    // -------------------------------------------------------------------------
    logic [XLEN-1:0] capture_data;

    always_comb begin
        capture_data = '0;
        case (mem_wb_sel)
            2'b00:   capture_data = mem_alu_result;
            2'b01:   capture_data = load_formatted;
            2'b10:   capture_data = mem_pc_plus4;
            default: capture_data = '0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state logic: reset > flush > stall > capture
    // -------------------------------------------------------------------------
    logic                      wb_valid_reg, wb_valid_next;
    logic                      wb_wr_en_reg, wb_wr_en_next;
    logic [REG_ADDR_WIDTH-1:0] wb_rd_reg, wb_rd_next;
    logic [XLEN-1:0]           wb_data_reg, wb_data_next;
    logic [63:0]               instret_reg, instret_next;

    always_comb begin
        wb_valid_next = wb_valid_reg;
        wb_wr_en_next = wb_wr_en_reg;
        wb_rd_next    = wb_rd_reg;
        wb_data_next  = wb_data_reg;
        instret_next  = instret_reg;
        if (flush) begin
            // rd/data keep their old contents; they are meaningless once
            // valid and write enable are cleared.
            wb_valid_next = 1'b0;
            wb_wr_en_next = 1'b0;
        end else if (!stall) begin
            wb_valid_next = mem_valid;
            wb_wr_en_next = mem_valid & mem_reg_write & (mem_rd != '0);
            wb_rd_next    = mem_rd;
            wb_data_next  = capture_data;
            if (mem_valid) begin
                instret_next = instret_reg + 64'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid_reg <= 1'b0;
            wb_wr_en_reg <= 1'b0;
            wb_rd_reg    <= '0;
            wb_data_reg  <= '0;
            instret_reg  <= 64'd0;
        end else begin
            wb_valid_reg <= wb_valid_next;
            wb_wr_en_reg <= wb_wr_en_next;
            wb_rd_reg    <= wb_rd_next;
            wb_data_reg  <= wb_data_next;
            instret_reg  <= instret_next;
        end
    end

    assign wb_valid      = wb_valid_reg;
    assign wb_wr_en      = wb_wr_en_reg;
    assign wb_rd         = wb_rd_reg;
    assign wb_write_data = wb_data_reg;
    assign instret       = instret_reg;

endmodule

// File: tb/tb_mem_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_stage
//
// Scoreboard bench for mem_wb_stage. The driver applies one set of inputs per
// cycle, computes the expected WB state from a behavioural model and pushes
// it; the monitor pops one entry on every falling edge and compares it with
// the DUT outputs.
// -----------------------------------------------------------------------------

module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic [1:0]  mem_wb_sel;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_pc_plus4;
    logic [31:0] mem_load_data;
    logic [2:0]  mem_funct3;
    logic        stall;
    logic        flush;
    logic [4:0]  wb_rd;
    logic [31:0] wb_write_data;
    logic        wb_wr_en;
    logic        wb_valid;
    logic [63:0] instret;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk            (clk),
        .reset          (reset),
        .mem_valid      (mem_valid),
        .mem_rd         (mem_rd),
        .mem_reg_write  (mem_reg_write),
        .mem_wb_sel     (mem_wb_sel),
        .mem_alu_result (mem_alu_result),
        .mem_pc_plus4   (mem_pc_plus4),
        .mem_load_data  (mem_load_data),
        .mem_funct3     (mem_funct3),
        .stall          (stall),
        .flush          (flush),
        .wb_rd          (wb_rd),
        .wb_write_data  (wb_write_data),
        .wb_wr_en       (wb_wr_en),
        .wb_valid       (wb_valid),
        .instret        (instret)
    );

    typedef struct {
        string       tag;
        bit          valid;
        bit          wr_en;
        bit [4:0]    rd;
        bit [31:0]   data;
        bit [63:0]   instret;
        bit          known;   // rd/data are defined (not after a flush)
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int passed = 0;
    int txn    = 0;

    // Model state
    bit        m_valid, m_wr_en, m_known;
    bit [4:0]  m_rd;
    bit [31:0] m_data;
    bit [63:0] m_instret;

    function automatic bit [31:0] fmt_load(bit [31:0] word, bit [1:0] off, bit [2:0] f3);
        bit [31:0] b, h;
        b = (word >> (8 * off)) & 32'hFF;
        h = (word >> (16 * off[1])) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            3'd5:    return h;
            default: return word;
        endcase
    endfunction

    task automatic chk(string tag, string name, logic [63:0] got, logic [63:0] want);
        checks++;
        if (got === want) begin
            passed++;
        end else begin
            $display("FAIL %s %s: got %h expected %h", tag, name, got, want);
        end
    endtask

    task automatic drive(string tag, bit rst, bit v, bit rw, bit [4:0] rd, bit [1:0] sel,
                         bit [31:0] alu, bit [31:0] pc4, bit [31:0] ld, bit [2:0] f3,
                         bit st, bit fl);
        exp_t e;
        reset = rst; mem_valid = v; mem_reg_write = rw; mem_rd = rd; mem_wb_sel = sel;
        mem_alu_result = alu; mem_pc_plus4 = pc4; mem_load_data = ld; mem_funct3 = f3;
        stall = st; flush = fl;
        if (rst) begin
            m_valid = 0; m_wr_en = 0; m_rd = 0; m_data = 0; m_instret = 0; m_known = 1;
        end else if (fl) begin
            m_valid = 0; m_wr_en = 0; m_known = 0;
        end else if (!st) begin
            m_valid = v;
            m_rd    = rd;
            m_wr_en = v && rw && (rd != 0);
            case (sel)
                2'd0:    m_data = alu;
                2'd1:    m_data = fmt_load(ld, alu[1:0], f3);
                2'd2:    m_data = pc4;
                default: m_data = 32'h0;
            endcase
            m_known = 1;
            if (v) m_instret = m_instret + 64'd1;
        end
        e.tag = tag; e.valid = m_valid; e.wr_en = m_wr_en; e.rd = m_rd;
        e.data = m_data; e.instret = m_instret; e.known = m_known;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expected entry per cycle, compared away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            txn++;
            chk(e.tag, "wb_valid", {63'd0, wb_valid}, {63'd0, e.valid});
            chk(e.tag, "wb_wr_en", {63'd0, wb_wr_en}, {63'd0, e.wr_en});
            chk(e.tag, "instret", instret, e.instret);
            if (e.known) begin
                chk(e.tag, "wb_rd", {59'd0, wb_rd}, {59'd0, e.rd});
                chk(e.tag, "wb_write_data", {32'd0, wb_write_data}, {32'd0, e.data});
            end
            $display("txn %0d %s: valid=%0b wr=%0b rd=%0d data=%h instret=%0d",
                     txn, e.tag, wb_valid, wb_wr_en, wb_rd, wb_write_data, instret);
        end
    end

    localparam bit [31:0] LD = 32'h80FF_7F01;

    initial begin
        // Reset
        drive("reset0", 1, 1, 1, 5'd3, 2'd0, 32'hDEAD, 32'h0, 32'h0, 3'd0, 1, 1);
        drive("reset1", 1, 0, 0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 3'd0, 0, 0);
        // ALU writeback
        drive("alu", 0, 1, 1, 5'd5, 2'd0, 32'h1234_5678, 32'h0, 32'h0, 3'd0, 0, 0);
        // Loads
        drive("lb3",  0, 1, 1, 5'd6, 2'd1, 32'h0000_1003, 32'h0, LD, 3'd0, 0, 0);
        drive("lbu1", 0, 1, 1, 5'd7, 2'd1, 32'h0000_1001, 32'h0, LD, 3'd4, 0, 0);
        drive("lh2",  0, 1, 1, 5'd8, 2'd1, 32'h0000_1002, 32'h0, LD, 3'd1, 0, 0);
        drive("lhu0", 0, 1, 1, 5'd9, 2'd1, 32'h0000_1000, 32'h0, LD, 3'd5, 0, 0);
        drive("lh_mis", 0, 1, 1, 5'd10, 2'd1, 32'h0000_1003, 32'h0, LD, 3'd1, 0, 0);
        drive("lw_mis", 0, 1, 1, 5'd11, 2'd1, 32'h0000_1002, 32'h0, LD, 3'd2, 0, 0);
        drive("sel11", 0, 1, 1, 5'd12, 2'd3, 32'hFFFF_FFFF, 32'h55, LD, 3'd2, 0, 0);
        // rd = 0 and bubble
        drive("rd0",    0, 1, 1, 5'd0, 2'd0, 32'hABCD, 32'h0, 32'h0, 3'd0, 0, 0);
        drive("bubble", 0, 0, 1, 5'd4, 2'd0, 32'h1111, 32'h0, 32'h0, 3'd0, 0, 0);
        // JAL then stall for 3 cycles with changing inputs
        drive("jal", 0, 1, 1, 5'd1, 2'd2, 32'h0, 32'h104, 32'h0, 3'd0, 0, 0);
        for (int i = 0; i < 3; i++)
            drive("stall", 0, 1, 1, 5'(i + 20), 2'd0, $urandom, $urandom, $urandom, 3'd0, 1, 0);
        // Flush and stall together with a valid load
        drive("flush", 0, 1, 1, 5'd13, 2'd1, 32'h0, 32'h0, LD, 3'd2, 1, 1);
        drive("refill", 0, 1, 1, 5'd14, 2'd0, 32'h77, 32'h0, 32'h0, 3'd0, 0, 0);
        // Reset mid-stream with instret at 7
        drive("rst_pre", 1, 0, 0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 3'd0, 0, 0);
        for (int i = 0; i < 7; i++)
            drive("pre", 0, 1, 1, 5'(i + 1), 2'd0, $urandom, 32'h0, 32'h0, 3'd0, 0, 0);
        drive("rst_mid", 1, 1, 1, 5'd9, 2'd0, 32'h99, 32'h0, 32'h0, 3'd0, 1, 0);
        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit [4:0] rd;
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            drive("rand", ($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom), rd,
                  2'($urandom), $urandom, $urandom, $urandom, 3'($urandom),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
        end
        // Let the monitor drain, with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        @(posedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
